// File: rtl/regfile_multiport.sv
// Multi-read-port integer register file with write-first bypass, hardwired r0
// and a sequenced post-reset clear that preloads the stack pointer.
module regfile_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned SP_INDEX = 29,
  parameter int unsigned SP_INIT  = 252
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteReg,
  input  logic [DATA_W-1:0]        WriteData,
  output logic                     Ready,
  output logic                     WrDropped
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                     state_q;
  logic [ADDR_W-1:0]          clr_idx_q;
  logic [ADDR_W-1:0]          clr_idx_d;
  logic                       ready_q;
  logic                       wr_dropped_q;
  logic [NUM_RD*DATA_W-1:0]   read_data_q;
  logic [DATA_W-1:0]          mem_q [DEPTH];

  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_waddr;
  logic [DATA_W-1:0]          mem_wdata;
  logic                       run_wr;

  assign clr_idx_d = clr_idx_q + ADDR_W'(1);
  assign run_wr    = RegWrite && (WriteReg != '0);

  // Single storage write port, shared between the clear sequencer and RUN writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = WriteReg;
    mem_wdata = WriteData;
    if (!Reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = (clr_idx_q == ADDR_W'(SP_INDEX)) ? DATA_W'(SP_INIT) : '0;
      end else if (run_wr) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Control state, handshake flags and registered read ports.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      ready_q      <= 1'b0;
      wr_dropped_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (RegWrite) begin
            wr_dropped_q <= 1'b1;
          end
          if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q   <= ST_RUN;
            ready_q   <= 1'b1;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_d;
          end
        end
        ST_RUN: begin
          for (int p = 0; p < NUM_RD; p++) begin
            if (ReadReg[p*ADDR_W +: ADDR_W] == '0) begin
              read_data_q[p*DATA_W +: DATA_W] <= '0;
            end else if (run_wr && (WriteReg == ReadReg[p*ADDR_W +: ADDR_W])) begin
              read_data_q[p*DATA_W +: DATA_W] <= WriteData;
            end else begin
              read_data_q[p*DATA_W +: DATA_W] <= mem_q[ReadReg[p*ADDR_W +: ADDR_W]];
            end
          end
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign ReadData  = read_data_q;
  assign Ready     = ready_q;
  assign WrDropped = wr_dropped_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: clear timing, reads, bypass, r0, dropped writes.
module tb_regfile_multiport;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic [NUM_RD*ADDR_W-1:0] ReadReg;
  logic [NUM_RD*DATA_W-1:0] ReadData;
  logic                     RegWrite;
  logic [ADDR_W-1:0]        WriteReg;
  logic [DATA_W-1:0]        WriteData;
  logic                     Ready;
  logic                     WrDropped;

  int errors = 0;
  int checks = 0;

  regfile_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .SP_INDEX(29), .SP_INIT(252)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ReadReg(ReadReg), .ReadData(ReadData),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .Ready(Ready), .WrDropped(WrDropped)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; outputs sampled at the following negedge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!Ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [NUM_RD*ADDR_W-1:0] rr(input int a1, input int a0);
    return {ADDR_W'(a1), ADDR_W'(a0)};
  endfunction

  int n;

  initial begin
    Reset = 1'b1; ReadReg = '0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    @(negedge Clk);
    tick();
    check("rst_ready", 64'(Ready), 64'd0);
    check("rst_wrdrop", 64'(WrDropped), 64'd0);
    check("rst_rdata", 64'(ReadData), 64'd0);

    Reset = 1'b0;
    wait_ready(n);
    check("clear_edges", 64'(n), 64'd32);

    ReadReg = rr(29, 5);
    tick();
    check("sp_init_p1", 64'(ReadData[63:32]), 64'd252);
    check("r5_zero_p0", 64'(ReadData[31:0]), 64'd0);

    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF; ReadReg = rr(0, 0);
    tick();
    RegWrite = 1'b0; ReadReg = rr(0, 8);
    tick();
    check("r8_read", 64'(ReadData[31:0]), 64'hDEADBEEF);

    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h12345678; ReadReg = rr(9, 9);
    tick();
    check("byp_p0", 64'(ReadData[31:0]), 64'h12345678);
    check("byp_p1", 64'(ReadData[63:32]), 64'h12345678);
    RegWrite = 1'b0; ReadReg = rr(8, 9);
    tick();
    check("r9_later", 64'(ReadData[31:0]), 64'h12345678);
    check("r8_p1", 64'(ReadData[63:32]), 64'hDEADBEEF);

    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg = rr(9, 0);
    tick();
    check("r0_nobyp", 64'(ReadData[31:0]), 64'd0);
    RegWrite = 1'b0; ReadReg = rr(0, 0);
    tick();
    check("r0_later", 64'(ReadData), 64'd0);
    check("run_nodrop", 64'(WrDropped), 64'd0);

    // Write attempted partway through CLEAR.
    Reset = 1'b1;
    tick();
    Reset = 1'b0; ReadReg = rr(3, 3);
    repeat (10) tick();
    check("clr_rdata", 64'(ReadData), 64'd0);
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h000000AA;
    tick();
    RegWrite = 1'b0;
    check("wrdrop_set", 64'(WrDropped), 64'd1);
    wait_ready(n);
    check("clear_rest", 64'(n), 64'd21);
    tick();
    check("r3_cleared", 64'(ReadData), 64'd0);
    check("wrdrop_sticky", 64'(WrDropped), 64'd1);

    // Reset mid-RUN, held for 3 edges, wipes r7 and reloads SP.
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h55; ReadReg = rr(29, 7);
    tick();
    RegWrite = 1'b0;
    check("r7_byp", 64'(ReadData[31:0]), 64'h55);
    Reset = 1'b1;
    tick();
    check("rst2_ready", 64'(Ready), 64'd0);
    check("rst2_rdata", 64'(ReadData), 64'd0);
    check("rst2_wrdrop", 64'(WrDropped), 64'd0);
    repeat (2) tick();
    Reset = 1'b0;
    wait_ready(n);
    check("clear_edges2", 64'(n), 64'd32);
    tick();
    check("r7_wiped", 64'(ReadData[31:0]), 64'd0);
    check("sp_reload", 64'(ReadData[63:32]), 64'd252);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
